shift_register_univ: RTL and testbench
======================================

Name: shift_register_univ

Overview:
- Parametrised successor to the team's 4-bit serial shift register.
- Generalised to WIDTH bits with a mode-selected operation set: hold, logical shifts, rotates, arithmetic shift, parallel load and clear.
- Adds a serial-shift counter with a registered word-complete pulse, so the block works as a deserialiser front-end, as a serialiser (LOAD then SHL/SHR out through so_l/so_r), or as a general datapath shifter.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 32.
- RST_VAL, 0, value q takes on reset (WIDTH bits).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  operation enable; 0 = full hold of all state.
- mode  in  3  operation select, sampled when en=1.
- din_l  in  1  serial input entering at bit 0 on SHL.
- din_r  in  1  serial input entering at bit WIDTH-1 on SHR.
- pdin  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- so_l  out  1  q[WIDTH-1]; the bit leaving on the next SHL.
- so_r  out  1  q[0]; the bit leaving on the next SHR.
- cnt  out  clog2(WIDTH+1)  serial shifts since last LOAD, CLEAR or wrap.
- word_vld  out  1  one-cycle pulse: WIDTH serial shifts completed.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk): q=RST_VAL, cnt=0, word_vld=0. Deassertion is synchronised externally.
- Reset mid-operation aborts any partial word; no word_vld is generated for it.
- All state updates on the rising edge of clk only. q, so_l, so_r and cnt reflect registered state; no combinational path from inputs to outputs.
- en=0: q and cnt hold; word_vld=0 on the following cycle.
- Mode encoding (en=1), next q:
  - 000 HOLD: q.
  - 001 SHL: {q[W-2:0], din_l}.
  - 010 SHR: {din_r, q[W-1:1]}.
  - 011 ROL: {q[W-2:0], q[W-1]}.
  - 100 ROR: {q[0], q[W-1:1]}.
  - 101 ASR: {q[W-1], q[W-1:1]}.
  - 110 LOAD: pdin.
  - 111 CLEAR: all zeros. CLEAR ignores RST_VAL.
- Counter:
  - Only SHL and SHR (with en=1) count as serial shifts.
  - If cnt==WIDTH-1 and a serial shift occurs: cnt becomes 0 and word_vld=1 for exactly the next cycle. The pulse coincides with q holding the completed word.
  - Otherwise a serial shift increments cnt by 1.
  - LOAD and CLEAR force cnt=0 and produce no pulse.
  - HOLD, ROL, ROR and ASR leave cnt unchanged.
  - SHL and SHR may be mixed; both increment the same counter.
  - cnt never reaches WIDTH; the wrap is modular.
- word_vld is registered and high for one cycle per completed word. Back-to-back words give pulses exactly WIDTH cycles apart under continuous shifting.
- Latency: one clock from the operation edge to q update. word_vld is asserted in the same cycle as the final q update.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5. Assert rst_n=0 between clock edges -> q=8'hA5, cnt=0, word_vld=0 immediately, without waiting for a clk edge.
- Deserialise: CLEAR, then 8 SHL cycles with din_l = 1,0,1,1,0,0,1,0 -> q=8'hB2, word_vld=1 only in the cycle after the 8th edge, cnt=0. Continue 8 more SHL cycles -> second pulse exactly 8 cycles later.
- Serialise: LOAD pdin=8'h81, then SHR with din_r=0 -> so_r sequence 1,0,0,0,0,0,0,1, final q=8'h00, word_vld pulses after the 8th shift.
- Rotate/arithmetic: LOAD 8'h96; ROL -> 8'h2D; ROR -> 8'h96; ASR -> 8'hCB; ASR -> 8'hE5. cnt remains 0, no word_vld.
- Enable and interrupt: 5 SHL cycles, en=0 for 3 cycles (q, cnt=5 held), 3 more SHL cycles -> pulse after the 3rd. Repeat with a LOAD after 5 shifts -> cnt=0, no pulse, a further 8 shifts are required for the next pulse.
- Mid-word reset: 4 SHL cycles of 1 from CLEAR (q=8'h0F, cnt=4), then a rst_n low pulse -> q=RST_VAL, cnt=0. The next 8 shifts produce exactly one pulse, at the 8th shift.

Source files
------------

// File: rtl/shift_register_univ_if.sv
// Bus bundle for shift_register_univ: control, serial/parallel data in, and
// register state out. WIDTH must match the attached shifter.
interface shift_register_univ_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic [2:0]       mode;
  logic             din_l;
  logic             din_r;
  logic [WIDTH-1:0] pdin;
  logic [WIDTH-1:0] q;
  logic             so_l;
  logic             so_r;
  logic [CNT_W-1:0] cnt;
  logic             word_vld;

  modport master (
    output en, mode, din_l, din_r, pdin,
    input  q, so_l, so_r, cnt, word_vld
  );

  modport slave (
    input  en, mode, din_l, din_r, pdin,
    output q, so_l, so_r, cnt, word_vld
  );
endinterface

// File: rtl/shift_register_univ.sv
// Universal WIDTH-bit shift register: hold, shifts, rotates, arithmetic shift,
// load and clear, with a serial-shift counter and registered word-complete pulse.
module shift_register_univ #(
  parameter int               WIDTH   = 8,   // legal range 2..32
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  shift_register_univ_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ASR   = 3'b101;
  localparam logic [2:0] MODE_LOAD  = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             vld_r, vld_nxt;
  logic             serial;
  logic             cnt_zero;

  // Next-state data path: selected operation on the current register.
  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    q_nxt    = q_r;
    serial   = 1'b0;
    cnt_zero = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD:  q_nxt = q_r;
        MODE_SHL: begin
          q_nxt  = {q_r[WIDTH-2:0], bus.din_l};
          serial = 1'b1;
        end
        MODE_SHR: begin
          q_nxt  = {bus.din_r, q_r[WIDTH-1:1]};
          serial = 1'b1;
        end
        MODE_ROL:   q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        MODE_ROR:   q_nxt = {q_r[0], q_r[WIDTH-1:1]};
        MODE_ASR:   q_nxt = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        MODE_LOAD: begin
          q_nxt    = bus.pdin;
          cnt_zero = 1'b1;
        end
        MODE_CLEAR: begin
          q_nxt    = '0;
          cnt_zero = 1'b1;
        end
        default:    q_nxt = q_r;
      endcase
    end
  end

  // Serial-shift counter: wraps modulo WIDTH, flagging the completed word.
  always_comb begin
    cnt_nxt = cnt_r;
    vld_nxt = 1'b0;
    if (cnt_zero) begin
      cnt_nxt = '0;
    end else if (serial) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt = '0;
        vld_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_r + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= RST_VAL;
      cnt_r <= '0;
      vld_r <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignment so all state updates see pre-edge values.
      q_r   <= q_nxt;
      cnt_r <= cnt_nxt;
      vld_r <= vld_nxt;
    end
  end

  assign bus.q        = q_r;
  assign bus.so_l     = q_r[WIDTH-1];
  assign bus.so_r     = q_r[0];
  assign bus.cnt      = cnt_r;
  assign bus.word_vld = vld_r;
endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8, RST_VAL=8'hA5).
module tb_shift_register_univ;
  localparam int WIDTH = 8;

  localparam logic [2:0] HOLD  = 3'b000;
  localparam logic [2:0] SHL   = 3'b001;
  localparam logic [2:0] SHR   = 3'b010;
  localparam logic [2:0] ROL   = 3'b011;
  localparam logic [2:0] ROR   = 3'b100;
  localparam logic [2:0] ASR   = 3'b101;
  localparam logic [2:0] LOAD  = 3'b110;
  localparam logic [2:0] CLEAR = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  shift_register_univ_if #(.WIDTH(WIDTH)) bus ();

  shift_register_univ #(
    .WIDTH  (WIDTH),
    .RST_VAL(8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] q_exp,
                             input logic [3:0] cnt_exp, input logic vld_exp);
    check({tag, ".q"}, 32'(bus.q), 32'(q_exp));
    check({tag, ".cnt"}, 32'(bus.cnt), 32'(cnt_exp));
    check({tag, ".word_vld"}, 32'(bus.word_vld), 32'(vld_exp));
  endtask

  // Drive one operation, clock it in, and settle 1 time unit past the edge.
  task automatic op(input logic e, input logic [2:0] m, input logic dl,
                    input logic dr, input logic [7:0] pd);
    bus.en    = e;
    bus.mode  = m;
    bus.din_l = dl;
    bus.din_r = dr;
    bus.pdin  = pd;
    @(posedge clk);
    #1;
  endtask

  // Pull reset low between edges and check the immediate effect.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_state(tag, 8'hA5, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] deser_q [8] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
  logic       deser_b [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] ser_q   [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
  logic       ser_so  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] ones_q  [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = HOLD;
    bus.din_l = 1'b0;
    bus.din_r = 1'b0;
    bus.pdin  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("por", 8'hA5, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset from a loaded value.
    op(1'b1, LOAD, 1'b0, 1'b0, 8'h3C);
    check_state("load3c", 8'h3C, 4'd0, 1'b0);
    async_reset("async_rst");

    // Deserialise two words back to back.
    op(1'b1, CLEAR, 1'b0, 1'b0, 8'h00);
    check_state("deser_clr", 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, SHL, deser_b[i], 1'b0, 8'h00);
      check_state($sformatf("deser%0d", i), deser_q[i], 4'((i + 1) % 8), (i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      op(1'b1, SHL, 1'b0, 1'b0, 8'h00);
      check($sformatf("deser2_%0d.cnt", i), 32'(bus.cnt), 32'((i + 1) % 8));
      check($sformatf("deser2_%0d.word_vld", i), 32'(bus.word_vld), 32'(i == 7));
    end
    check("deser2.q", 32'(bus.q), 32'h00);

    // Serialise 8'h81 out through so_r.
    op(1'b1, LOAD, 1'b0, 1'b0, 8'h81);
    check_state("ser_load", 8'h81, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser%0d.so_r", i), 32'(bus.so_r), 32'(ser_so[i]));
      op(1'b1, SHR, 1'b0, 1'b0, 8'h00);
      check_state($sformatf("ser%0d", i), ser_q[i], 4'((i + 1) % 8), (i == 7));
    end

    // Rotates and arithmetic shift never touch the counter.
    op(1'b1, LOAD, 1'b0, 1'b0, 8'h96);
    check("rot_load.so_l", 32'(bus.so_l), 32'h1);
    op(1'b1, ROL, 1'b1, 1'b1, 8'h00);
    check_state("rol", 8'h2D, 4'd0, 1'b0);
    op(1'b1, ROR, 1'b0, 1'b0, 8'h00);
    check_state("ror", 8'h96, 4'd0, 1'b0);
    op(1'b1, ASR, 1'b0, 1'b0, 8'h00);
    check_state("asr1", 8'hCB, 4'd0, 1'b0);
    op(1'b1, ASR, 1'b0, 1'b0, 8'h00);
    check_state("asr2", 8'hE5, 4'd0, 1'b0);
    op(1'b1, HOLD, 1'b1, 1'b1, 8'h00);
    check_state("hold", 8'hE5, 4'd0, 1'b0);

    // Enable low mid-word holds q and cnt even with CLEAR selected.
    op(1'b1, CLEAR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    check_state("en_pre", 8'h1F, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, CLEAR, 1'b0, 1'b0, 8'h00);
      check_state($sformatf("en_hold%0d", i), 8'h1F, 4'd5, 1'b0);
    end
    op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    check_state("en_post0", 8'h3F, 4'd6, 1'b0);
    op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    check_state("en_post1", 8'h7F, 4'd7, 1'b0);
    op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    check_state("en_post2", 8'hFF, 4'd0, 1'b1);
    op(1'b0, SHL, 1'b1, 1'b0, 8'h00);
    check_state("en_after", 8'hFF, 4'd0, 1'b0);

    // LOAD mid-word restarts the count; mixed SHL/SHR complete the next word.
    op(1'b1, CLEAR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    op(1'b1, LOAD, 1'b0, 1'b0, 8'h5A);
    check_state("ld_mid", 8'h5A, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, (i < 4) ? SHL : SHR, 1'b0, 1'b0, 8'h00);
      check($sformatf("ld_mix%0d.cnt", i), 32'(bus.cnt), 32'((i + 1) % 8));
      check($sformatf("ld_mix%0d.word_vld", i), 32'(bus.word_vld), 32'(i == 7));
    end
    // 5A <<4 = A0, then >>4 with zeros = 0A
    check("ld_mix.q", 32'(bus.q), 32'h0A);

    // Reset in the middle of a word discards it.
    op(1'b1, CLEAR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
    check_state("mid_pre", 8'h0F, 4'd4, 1'b0);
    async_reset("mid_rst");
    op(1'b1, CLEAR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      op(1'b1, SHL, 1'b1, 1'b0, 8'h00);
      check_state($sformatf("mid_post%0d", i), ones_q[i], 4'((i + 1) % 8), (i == 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
